// File: rtl/alu_vec_ctrl.sv
// rtl/alu_vec_ctrl.sv - round-robin controller sharing one multicycle vector ALU between two requesters
//
// Purpose: grants one of two requesters, registers its operands/opcode toward the
// ALU for ALU_LAT cycles, then captures result and flags into a response register
// held under valid/ready backpressure.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   req_valid/req_ready [1:0]         per-requester handshake (ready is combinational)
//   req_a/req_b [2*VEC_W-1:0]         operands, requester i at [i*VEC_W +: VEC_W]
//   req_opcode [5:0]                  opcodes, requester i at [i*3 +: 3]
//   req_flag_scalar [1:0]             scalar-mode flag per requester
//   alu_a/alu_b/alu_opcode/alu_flag_scalar   registered ALU operands
//   alu_result/alu_flags              ALU outputs
//   rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_flags   response channel
//   busy                              high whenever the FSM is not idle
module alu_vec_ctrl #(
  parameter int VEC_W   = 256,
  parameter int FLAG_W  = 64,
  parameter int ALU_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*VEC_W-1:0]   req_a,
  input  logic [2*VEC_W-1:0]   req_b,
  input  logic [5:0]           req_opcode,
  input  logic [1:0]           req_flag_scalar,
  output logic [VEC_W-1:0]     alu_a,
  output logic [VEC_W-1:0]     alu_b,
  output logic [2:0]           alu_opcode,
  output logic                 alu_flag_scalar,
  input  logic [VEC_W-1:0]     alu_result,
  input  logic [FLAG_W-1:0]    alu_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [VEC_W-1:0]     rsp_result,
  output logic [FLAG_W-1:0]    rsp_flags,
  output logic                 busy
);

  localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ALU_LAT - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_e;

  state_e            state_q;
  logic              prio_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [VEC_W-1:0]  alu_a_q, alu_b_q, rsp_result_q;
  logic [2:0]        alu_opcode_q;
  logic              alu_flag_scalar_q, rsp_valid_q, rsp_id_q;
  logic [FLAG_W-1:0] rsp_flags_q;

  logic grant_valid;
  logic grant_id;

  // Contention resolves to prio_q; a lone requester wins regardless of priority.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    if (req_valid == 2'b11) begin
      grant_valid = 1'b1;
      grant_id    = prio_q;
    end else if (req_valid[0]) begin
      grant_valid = 1'b1;
      grant_id    = 1'b0;
    end else if (req_valid[1]) begin
      grant_valid = 1'b1;
      grant_id    = 1'b1;
    end
  end

  always_comb begin
    req_ready = 2'b00;
    if (!rst && state_q == IDLE && grant_valid) begin
      req_ready = grant_id ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= IDLE;
      prio_q            <= 1'b0;
      cnt_q             <= '0;
      alu_a_q           <= '0;
      alu_b_q           <= '0;
      alu_opcode_q      <= '0;
      alu_flag_scalar_q <= 1'b0;
      rsp_valid_q       <= 1'b0;
      rsp_id_q          <= 1'b0;
      rsp_result_q      <= '0;
      rsp_flags_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_valid) begin
            alu_a_q           <= grant_id ? req_a[2*VEC_W-1:VEC_W] : req_a[VEC_W-1:0];
            alu_b_q           <= grant_id ? req_b[2*VEC_W-1:VEC_W] : req_b[VEC_W-1:0];
            alu_opcode_q      <= grant_id ? req_opcode[5:3] : req_opcode[2:0];
            alu_flag_scalar_q <= req_flag_scalar[grant_id];
            rsp_id_q          <= grant_id;
            prio_q            <= ~grant_id;
            cnt_q             <= CNT_INIT;
            state_q           <= EXEC;
          end
        end
        EXEC: begin
          // Operands stay untouched here so the ALU path gets ALU_LAT full cycles.
          if (cnt_q == '0) begin
            rsp_result_q <= alu_result;
            rsp_flags_q  <= alu_flags;
            rsp_valid_q  <= 1'b1;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          // No grant in this cycle: the next handshake can only happen from IDLE.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a           = alu_a_q;
  assign alu_b           = alu_b_q;
  assign alu_opcode      = alu_opcode_q;
  assign alu_flag_scalar = alu_flag_scalar_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = rsp_id_q;
  assign rsp_result      = rsp_result_q;
  assign rsp_flags       = rsp_flags_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_alu_vec_ctrl.sv
// tb/tb_alu_vec_ctrl.sv - directed table-driven bench for alu_vec_ctrl
module tb_alu_vec_ctrl;
  localparam int VEC_W   = 256;
  localparam int FLAG_W  = 64;
  localparam int ALU_LAT = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [1:0]         req_valid = 2'b00;
  logic [1:0]         req_ready;
  logic [2*VEC_W-1:0] req_a = '0;
  logic [2*VEC_W-1:0] req_b = '0;
  logic [5:0]         req_opcode = '0;
  logic [1:0]         req_flag_scalar = '0;
  logic [VEC_W-1:0]   alu_a, alu_b, alu_result, rsp_result;
  logic [2:0]         alu_opcode;
  logic               alu_flag_scalar, rsp_valid, rsp_id, busy;
  logic               rsp_ready = 1'b0;
  logic [FLAG_W-1:0]  alu_flags, rsp_flags;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_vec_ctrl #(.VEC_W(VEC_W), .FLAG_W(FLAG_W), .ALU_LAT(ALU_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_opcode(req_opcode), .req_flag_scalar(req_flag_scalar),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_flag_scalar(alu_flag_scalar),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
  );

  // Stand-in ALU: per 16-bit lane add (000), sub (001), xor (others); flags = {scalar, opcode} per lane.
  function automatic logic [VEC_W-1:0] alu_model(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b,
                                                 input logic [2:0] op);
    logic [VEC_W-1:0] r;
    r = '0;
    for (int l = 0; l < 16; l++) begin
      case (op)
        3'b000:  r[l*16 +: 16] = a[l*16 +: 16] + b[l*16 +: 16];
        3'b001:  r[l*16 +: 16] = a[l*16 +: 16] - b[l*16 +: 16];
        default: r[l*16 +: 16] = a[l*16 +: 16] ^ b[l*16 +: 16];
      endcase
    end
    return r;
  endfunction

  always_comb begin
    alu_result = alu_model(alu_a, alu_b, alu_opcode);
    alu_flags  = {16{alu_flag_scalar, alu_opcode}};
  end

  typedef struct {
    logic [1:0]       v;
    logic [VEC_W-1:0] a;
    logic [VEC_W-1:0] b;
    logic [2:0]       op;
    logic             sc;
    logic             id;
    logic [VEC_W-1:0] res;
    logic [FLAG_W-1:0] fl;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one request (junk in the other requester's slot), checks grant, latched operands,
  // capture latency and the response contents. Returns just after rsp_valid is seen high.
  task automatic run_vec(input vec_t t);
    int n;
    @(negedge clk);
    req_a           = t.id ? {t.a, ~t.a} : {~t.a, t.a};
    req_b           = t.id ? {t.b, ~t.b} : {~t.b, t.b};
    req_opcode      = t.id ? {t.op, ~t.op} : {~t.op, t.op};
    req_flag_scalar = t.id ? {t.sc, ~t.sc} : {~t.sc, t.sc};
    req_valid       = t.v;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("grant", VEC_W'(req_ready), VEC_W'(t.id ? 2'b10 : 2'b01));
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    chk("alu_a", alu_a, t.a);
    chk("alu_b", alu_b, t.b);
    chk("alu_op_sc", VEC_W'({alu_opcode, alu_flag_scalar}), VEC_W'({t.op, t.sc}));
    chk("busy_exec", VEC_W'(busy), VEC_W'(1));
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", VEC_W'(n), VEC_W'(ALU_LAT));
    chk("rsp_id", VEC_W'(rsp_id), VEC_W'(t.id));
    chk("rsp_result", rsp_result, t.res);
    chk("rsp_flags", VEC_W'(rsp_flags), VEC_W'(t.fl));
  endtask

  initial begin
    int n, nh, rises;
    logic ids[4];
    int cyc[4];
    vec_t bp;

    tbl[0] = '{2'b01, {8{32'h0180_0140}}, {8{32'hFE40_0180}}, 3'b000, 1'b0, 1'b0,
               {8{32'hFFC0_02C0}}, 64'h0};
    tbl[1] = '{2'b10, {16{16'h1234}}, {16{16'h0034}}, 3'b001, 1'b0, 1'b1,
               {16{16'h1200}}, {16{4'h1}}};
    tbl[2] = '{2'b01, {16{16'hAAAA}}, {16{16'h5555}}, 3'b111, 1'b1, 1'b0,
               {16{16'hFFFF}}, {16{4'hF}}};
    tbl[3] = '{2'b10, {16{16'h8000}}, {16{16'h8000}}, 3'b000, 1'b1, 1'b1,
               {16{16'h0000}}, {16{4'h8}}};

    // Reset with both requesters asserting.
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b11;
    @(posedge clk);
    #1;
    chk("rst_ready_1", VEC_W'(req_ready), '0);
    @(posedge clk);
    #1;
    chk("rst_ready_2", VEC_W'(req_ready), '0);
    chk("rst_rsp_valid", VEC_W'(rsp_valid), '0);
    chk("rst_busy", VEC_W'(busy), '0);
    chk("rst_alu_a", alu_a, '0);
    chk("rst_alu_b", alu_b, '0);
    chk("rst_alu_op_sc", VEC_W'({alu_opcode, alu_flag_scalar}), '0);
    chk("rst_rsp_id", VEC_W'(rsp_id), '0);
    chk("rst_rsp_result", rsp_result, '0);
    chk("rst_rsp_flags", VEC_W'(rsp_flags), '0);
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b0;

    // Table vectors, response always accepted.
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) run_vec(tbl[i]);

    // Fairness: both requesting continuously from a fresh priority.
    do_reset();
    req_a = {~tbl[2].a, tbl[2].a};
    req_b = {~tbl[2].b, tbl[2].b};
    req_valid = 2'b11;
    nh = 0;
    for (int c = 0; c < 24; c++) begin
      #1;
      if (req_ready != 2'b00 && nh < 4) begin
        ids[nh] = req_ready[1];
        cyc[nh] = c;
        nh++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    chk("fair_count", VEC_W'(nh), VEC_W'(4));
    for (int k = 0; k < 4; k++) begin
      if (k < nh) chk("fair_id", VEC_W'(ids[k]), VEC_W'(k % 2));
      if (k > 0 && k < nh) chk("fair_period", VEC_W'(cyc[k] - cyc[k-1]), VEC_W'(ALU_LAT + 2));
    end

    // Backpressure with requester 1 waiting.
    do_reset();
    rsp_ready = 1'b0;
    bp = tbl[0];
    run_vec(bp);
    @(negedge clk);
    req_a = {tbl[1].a, tbl[1].b};
    req_valid = 2'b10;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", VEC_W'(rsp_valid), VEC_W'(1));
      chk("bp_result", rsp_result, bp.res);
      chk("bp_busy", VEC_W'(busy), VEC_W'(1));
      chk("bp_ready", VEC_W'(req_ready), '0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_idle", VEC_W'({busy, rsp_valid}), '0);
    chk("bp_grant1", VEC_W'(req_ready), VEC_W'(2'b10));
    chk("bp_keep", rsp_result, bp.res);
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    chk("bp_busy2", VEC_W'(busy), VEC_W'(1));
    chk("bp_alu_a", alu_a, tbl[1].a);
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_rsp_id", VEC_W'(rsp_id), VEC_W'(1));

    // Reset during EXEC drops the op and restores priority 0.
    do_reset();
    req_a = {tbl[3].a, tbl[0].a};
    req_valid = 2'b01;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    chk("mid_busy", VEC_W'(busy), VEC_W'(1));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_alu_a", alu_a, '0);
    @(negedge clk);
    rst = 1'b0;
    rises = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid || busy) rises++;
    end
    chk("mid_no_rsp", VEC_W'(rises), '0);
    @(negedge clk);
    req_valid = 2'b11;
    #1;
    chk("mid_prio", VEC_W'(req_ready), VEC_W'(2'b01));
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    n = 0;
    while (busy && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end

    // Scalar op from requester 1; request inputs changed after handshake must not leak.
    @(negedge clk);
    req_opcode = {3'b010, 3'b101};
    req_flag_scalar = 2'b10;
    req_valid = 2'b10;
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    req_opcode = 6'b111_111;
    req_flag_scalar = 2'b00;
    for (int k = 0; k < ALU_LAT; k++) begin
      chk("sc_op", VEC_W'({alu_opcode, alu_flag_scalar}), VEC_W'(4'b0101));
      @(posedge clk);
      #1;
    end
    chk("sc_valid", VEC_W'(rsp_valid), VEC_W'(1));
    chk("sc_id", VEC_W'(rsp_id), VEC_W'(1));
    chk("sc_flags", VEC_W'(rsp_flags), VEC_W'({16{4'hA}}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
